ppu_timing_gen: RTL and testbench

PPU_TIMING_GEN -- requirements
Module: ppu_timing_gen

---
 rtl/ppu_pkg.sv | 21 ++
 rtl/ppu_wrap_counter.sv | 70 +++++++
 rtl/ppu_timing_gen.sv | 108 ++++++++++
 tb/tb_ppu_timing_gen.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU raster timing generator.
// Holds the NTSC default timing constants, the counter width and the
// packed screen-position type passed between the counter and the top.
package ppu_pkg;

  localparam int NTSC_H_TOTAL     = 341;
  localparam int NTSC_V_TOTAL     = 262;
  localparam int NTSC_H_VISIBLE   = 256;
  localparam int NTSC_V_VISIBLE   = 240;
  localparam int NTSC_VBLANK_LINE = 241;
  localparam int NTSC_PRE_LINE    = NTSC_V_TOTAL - 1;

  // Wide enough for any dot or line index up to 511.
  localparam int POS_W = 9;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } ppu_pos_t;

endpackage

// File: rtl/ppu_wrap_counter.sv
// Dot/scanline counter pair with frame parity and the odd-frame dot skip.
// Ports:
//   clk        - dot clock (rising edge)
//   rst_n      - asynchronous active-low reset, forces (0,0) and even parity
//   en         - advance enable; counters and parity hold while low
//   render_en  - rendering active, qualifies the odd-frame skip
//   pos        - current (x,y) position
//   odd_frame  - frame parity
//   line_wrap  - the next enabled edge loads x=0
//   frame_wrap - the next enabled edge loads (0,0)
module ppu_wrap_counter
  import ppu_pkg::*;
#(
  parameter int H_TOTAL  = NTSC_H_TOTAL,
  parameter int V_TOTAL  = NTSC_V_TOTAL,
  parameter int PRE_LINE = NTSC_PRE_LINE,
  parameter int ODD_SKIP = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  logic     render_en,
  output ppu_pos_t pos,
  output logic     odd_frame,
  output logic     line_wrap,
  output logic     frame_wrap
);

  localparam logic [POS_W-1:0] X_LAST = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] X_SKIP = POS_W'(H_TOTAL - 2);
  localparam logic [POS_W-1:0] Y_LAST = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] Y_PRE  = POS_W'(PRE_LINE);

  logic     x_last;
  logic     y_last;
  logic     skip;
  ppu_pos_t pos_next;

  always_comb begin
    x_last = (pos.x == X_LAST);
    y_last = (pos.y == Y_LAST);
    // On odd rendered frames the last dot of the pre-render line is dropped:
    // the dot before it jumps straight to the start of the next frame.
    skip       = (ODD_SKIP != 0) && render_en && odd_frame &&
                 (pos.x == X_SKIP) && (pos.y == Y_PRE);
    line_wrap  = skip || x_last;
    frame_wrap = skip || (x_last && y_last);

    pos_next = pos;
    if (line_wrap) begin
      pos_next.x = '0;
      pos_next.y = frame_wrap ? '0 : pos.y + 1'b1;
    end else begin
      pos_next.x = pos.x + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos       <= '0;
      odd_frame <= 1'b0;
    end else if (en) begin
      pos <= pos_next;
      if (frame_wrap) begin
        odd_frame <= ~odd_frame;
      end
    end
  end

endmodule

// File: rtl/ppu_timing_gen.sv
// PPU raster timing generator: dot/line position, visible-area decode,
// PPUSTATUS vblank flag with $2002 read-clear, NMI request level and
// one-cycle line/frame start pulses.
// Ports:
//   PPU_SLOW_CLOCK - dot clock (rising edge)
//   RST_N          - asynchronous active-low reset
//   EN             - dot advance enable
//   NMI_EN         - PPUCTRL bit 7
//   RENDER_EN      - background or sprite rendering on
//   STATUS_RD      - one-cycle pulse on a CPU read of $2002
//   PIXEL_X/Y      - current dot / scanline
//   VISIBLE        - position lies inside the visible area
//   VBLANK         - PPUSTATUS bit 7
//   NMI            - active-high NMI request level
//   FRAME_START    - one cycle after each load of (0,0)
//   LINE_START     - one cycle after each load of x=0
//   ODD_FRAME      - frame parity
module ppu_timing_gen
  import ppu_pkg::*;
#(
  parameter int H_TOTAL     = NTSC_H_TOTAL,
  parameter int V_TOTAL     = NTSC_V_TOTAL,
  parameter int H_VISIBLE   = NTSC_H_VISIBLE,
  parameter int V_VISIBLE   = NTSC_V_VISIBLE,
  parameter int VBLANK_LINE = NTSC_VBLANK_LINE,
  parameter int PRE_LINE    = V_TOTAL - 1,
  parameter int ODD_SKIP    = 1
) (
  input  logic       PPU_SLOW_CLOCK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       NMI_EN,
  input  logic       RENDER_EN,
  input  logic       STATUS_RD,
  output logic [8:0] PIXEL_X,
  output logic [8:0] PIXEL_Y,
  output logic       VISIBLE,
  output logic       VBLANK,
  output logic       NMI,
  output logic       FRAME_START,
  output logic       LINE_START,
  output logic       ODD_FRAME
);

  localparam logic [POS_W-1:0] X_VIS   = POS_W'(H_VISIBLE);
  localparam logic [POS_W-1:0] Y_VIS   = POS_W'(V_VISIBLE);
  localparam logic [POS_W-1:0] Y_VBL   = POS_W'(VBLANK_LINE);
  localparam logic [POS_W-1:0] Y_PRE   = POS_W'(PRE_LINE);

  ppu_pos_t pos;
  logic     line_wrap;
  logic     frame_wrap;
  logic     set_evt;
  logic     clr_evt;
  logic     vblank_next;

  ppu_wrap_counter #(
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .PRE_LINE (PRE_LINE),
    .ODD_SKIP (ODD_SKIP)
  ) u_counter (
    .clk        (PPU_SLOW_CLOCK),
    .rst_n      (RST_N),
    .en         (EN),
    .render_en  (RENDER_EN),
    .pos        (pos),
    .odd_frame  (ODD_FRAME),
    .line_wrap  (line_wrap),
    .frame_wrap (frame_wrap)
  );

  assign PIXEL_X = pos.x;
  assign PIXEL_Y = pos.y;
  assign VISIBLE = (pos.x < X_VIS) && (pos.y < Y_VIS);

  always_comb begin
    // Flag events fire on the enabled edge leaving dot 0 of the line.
    set_evt = EN && (pos.x == '0) && (pos.y == Y_VBL);
    clr_evt = EN && (pos.x == '0) && (pos.y == Y_PRE);

    // A $2002 read landing on the set edge wins, suppressing that frame's
    // flag (and therefore its NMI).
    vblank_next = VBLANK;
    if (STATUS_RD || clr_evt) begin
      vblank_next = 1'b0;
    end else if (set_evt) begin
      vblank_next = 1'b1;
    end
  end

  always_ff @(posedge PPU_SLOW_CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      VBLANK      <= 1'b0;
      NMI         <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      VBLANK      <= vblank_next;
      // Built from the next flag value so NMI tracks VBLANK and NMI_EN
      // without an extra cycle of lag.
      NMI         <= vblank_next & NMI_EN;
      LINE_START  <= EN & line_wrap;
      FRAME_START <= EN & frame_wrap;
    end
  end

endmodule

// File: tb/tb_ppu_timing_gen.sv
// Directed testbench for ppu_timing_gen. The main instance uses a scaled-down
// raster (24 dots x 16 lines) so whole frames stay short; a second instance
// with the NTSC defaults checks the first scanline of the default geometry.
module tb_ppu_timing_gen;

  localparam int HT    = 24;
  localparam int VT    = 16;
  localparam int HV    = 16;
  localparam int VV    = 10;
  localparam int VBL   = 11;
  localparam int PRE   = 15;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, nmi_en, render_en, status_rd, rst_n2;
  logic [8:0] px, py, nx, ny;
  logic       visible, vblank, nmi, frame_start, line_start, odd_frame;
  logic       nvis, nvb, nnmi, nfs, nls, nodd;

  int checks   = 0;
  int failures = 0;

  ppu_timing_gen #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_VISIBLE(HV), .V_VISIBLE(VV),
    .VBLANK_LINE(VBL), .PRE_LINE(PRE), .ODD_SKIP(1)
  ) dut (
    .PPU_SLOW_CLOCK(clk), .RST_N(rst_n), .EN(en), .NMI_EN(nmi_en),
    .RENDER_EN(render_en), .STATUS_RD(status_rd),
    .PIXEL_X(px), .PIXEL_Y(py), .VISIBLE(visible), .VBLANK(vblank),
    .NMI(nmi), .FRAME_START(frame_start), .LINE_START(line_start),
    .ODD_FRAME(odd_frame)
  );

  ppu_timing_gen dut_ntsc (
    .PPU_SLOW_CLOCK(clk), .RST_N(rst_n2), .EN(1'b1), .NMI_EN(1'b0),
    .RENDER_EN(1'b1), .STATUS_RD(1'b0),
    .PIXEL_X(nx), .PIXEL_Y(ny), .VISIBLE(nvis), .VBLANK(nvb),
    .NMI(nnmi), .FRAME_START(nfs), .LINE_START(nls), .ODD_FRAME(nodd)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance until the main instance sits at (tx,ty); ok=0 if the bound expires.
  task automatic goto(input int tx, input int ty, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= 2 * FRAME; i++) begin
      if (int'(px) == tx && int'(py) == ty) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  // Run from (0,0) until FRAME_START, recording event cycle numbers.
  task automatic measure_frame(output int len, output int vb_rise, output int vb_fall,
                               output int nmi_rise, output int nmi_fall, output int vis_cnt,
                               output int ls_cnt, output int after_x, output int after_y);
    int prev_x, prev_y;
    len = -1; vb_rise = -1; vb_fall = -1; nmi_rise = -1; nmi_fall = -1;
    vis_cnt = 0; ls_cnt = 0; after_x = -1; after_y = -1;
    prev_x = int'(px); prev_y = int'(py);
    for (int c = 1; c <= FRAME + 16; c++) begin
      step(1);
      if (visible) vis_cnt++;
      if (line_start) ls_cnt++;
      if (vblank && vb_rise < 0) vb_rise = c;
      if (!vblank && vb_rise >= 0 && vb_fall < 0) vb_fall = c;
      if (nmi && nmi_rise < 0) nmi_rise = c;
      if (!nmi && nmi_rise >= 0 && nmi_fall < 0) nmi_fall = c;
      if (prev_x == HT - 2 && prev_y == PRE) begin
        after_x = int'(px);
        after_y = int'(py);
      end
      prev_x = int'(px); prev_y = int'(py);
      if (frame_start) begin
        len = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rst_n2 = 1'b0; en = 1'b0; nmi_en = 1'b0;
    render_en = 1'b1; status_rd = 1'b0;
    step(2);
    checks++;
    if (px !== 9'd0 || py !== 9'd0) begin
      failures++; $display("FAIL reset_pos got=(%0d,%0d) exp=(0,0)", px, py);
    end
    checks++;
    if ({vblank, nmi, frame_start, line_start, odd_frame} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {vblank, nmi, frame_start, line_start, odd_frame});
    end
    checks++;
    if (visible !== 1'b1) begin
      failures++; $display("FAIL reset_visible got=%b exp=1", visible);
    end
    rst_n = 1'b1; en = 1'b1;
    step(1);
    checks++;
    if (px !== 9'd1 || py !== 9'd0) begin
      failures++; $display("FAIL first_edge_pos got=(%0d,%0d) exp=(1,0)", px, py);
    end
    checks++;
    if (frame_start !== 1'b0 || line_start !== 1'b0) begin
      failures++; $display("FAIL first_edge_pulse got fs=%b ls=%b exp=0,0", frame_start, line_start);
    end
  endtask

  task automatic test_even_frame;
    int len, vr, vf, nr, nf, vis, ls, ax, ay;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1; nmi_en = 1'b1; render_en = 1'b1; en = 1'b1;
    measure_frame(len, vr, vf, nr, nf, vis, ls, ax, ay);
    checks++;
    if (len != FRAME) begin failures++; $display("FAIL even_len got=%0d exp=%0d", len, FRAME); end
    checks++;
    if (odd_frame !== 1'b1) begin failures++; $display("FAIL even_odd_flag got=%b exp=1", odd_frame); end
    checks++;
    if (px !== 9'd0 || py !== 9'd0) begin
      failures++; $display("FAIL even_end_pos got=(%0d,%0d) exp=(0,0)", px, py);
    end
    checks++;
    if (vr != VBL * HT + 1 || vf != PRE * HT + 1) begin
      failures++; $display("FAIL vblank_window got=%0d..%0d exp=%0d..%0d", vr, vf, VBL*HT+1, PRE*HT+1);
    end
    checks++;
    if (nr != VBL * HT + 1 || nf != PRE * HT + 1) begin
      failures++; $display("FAIL nmi_window got=%0d..%0d exp=%0d..%0d", nr, nf, VBL*HT+1, PRE*HT+1);
    end
    checks++;
    if (vis != HV * VV) begin failures++; $display("FAIL visible_count got=%0d exp=%0d", vis, HV*VV); end
    checks++;
    if (ls != VT) begin failures++; $display("FAIL line_start_count got=%0d exp=%0d", ls, VT); end
  endtask

  task automatic test_odd_frame;
    int len, vr, vf, nr, nf, vis, ls, ax, ay;
    measure_frame(len, vr, vf, nr, nf, vis, ls, ax, ay);
    checks++;
    if (len != FRAME - 1) begin failures++; $display("FAIL odd_len got=%0d exp=%0d", len, FRAME-1); end
    checks++;
    if (ax != 0 || ay != 0) begin
      failures++; $display("FAIL odd_skip_next got=(%0d,%0d) exp=(0,0)", ax, ay);
    end
    checks++;
    if (odd_frame !== 1'b0) begin failures++; $display("FAIL odd_toggle got=%b exp=0", odd_frame); end
    checks++;
    if (ls != VT) begin failures++; $display("FAIL odd_line_starts got=%0d exp=%0d", ls, VT); end
  endtask

  task automatic test_odd_norender;
    int len, vr, vf, nr, nf, vis, ls, ax, ay;
    measure_frame(len, vr, vf, nr, nf, vis, ls, ax, ay);
    checks++;
    if (len != FRAME) begin failures++; $display("FAIL even2_len got=%0d exp=%0d", len, FRAME); end
    render_en = 1'b0;
    measure_frame(len, vr, vf, nr, nf, vis, ls, ax, ay);
    checks++;
    if (len != FRAME) begin failures++; $display("FAIL norender_len got=%0d exp=%0d", len, FRAME); end
    checks++;
    if (ax != HT - 1 || ay != PRE) begin
      failures++; $display("FAIL norender_next got=(%0d,%0d) exp=(%0d,%0d)", ax, ay, HT-1, PRE);
    end
    checks++;
    if (odd_frame !== 1'b0) begin failures++; $display("FAIL norender_odd got=%b exp=0", odd_frame); end
    render_en = 1'b1;
  endtask

  task automatic test_read_race;
    bit ok, done;
    int vb_hits, nmi_hits;
    nmi_en = 1'b1;
    goto(0, VBL, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL race_goto got=(%0d,%0d) exp=(0,%0d)", px, py, VBL); end
    status_rd = 1'b1;
    step(1);
    status_rd = 1'b0;
    checks++;
    if (vblank !== 1'b0 || nmi !== 1'b0) begin
      failures++; $display("FAIL race_set_edge got vb=%b nmi=%b exp=0,0", vblank, nmi);
    end
    vb_hits = 0; nmi_hits = 0; done = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      step(1);
      if (vblank) vb_hits++;
      if (nmi) nmi_hits++;
      if (frame_start) begin done = 1'b1; break; end
    end
    checks++;
    if (!done || vb_hits != 0 || nmi_hits != 0) begin
      failures++; $display("FAIL race_frame got done=%b vb=%0d nmi=%0d exp=1,0,0", done, vb_hits, nmi_hits);
    end
  endtask

  task automatic test_nmi_toggle;
    bit ok;
    nmi_en = 1'b0;
    goto(5, 13, ok);
    checks++;
    if (!ok || vblank !== 1'b1 || nmi !== 1'b0) begin
      failures++; $display("FAIL nmi_pre got ok=%b vb=%b nmi=%b exp=1,1,0", ok, vblank, nmi);
    end
    nmi_en = 1'b1; step(1);
    checks++;
    if (nmi !== 1'b1) begin failures++; $display("FAIL nmi_en_rise got=%b exp=1", nmi); end
    nmi_en = 1'b0; step(1);
    checks++;
    if (nmi !== 1'b0) begin failures++; $display("FAIL nmi_en_fall got=%b exp=0", nmi); end
    nmi_en = 1'b1; step(1);
    status_rd = 1'b1; step(1); status_rd = 1'b0;
    checks++;
    if (vblank !== 1'b0 || nmi !== 1'b0) begin
      failures++; $display("FAIL status_read_clear got vb=%b nmi=%b exp=0,0", vblank, nmi);
    end
  endtask

  task automatic test_en_gating;
    bit ok;
    goto(5, 3, ok);
    en = 1'b0; step(10);
    checks++;
    if (!ok || px !== 9'd5 || py !== 9'd3) begin
      failures++; $display("FAIL en_freeze got=(%0d,%0d) exp=(5,3)", px, py);
    end
    en = 1'b1; step(1);
    checks++;
    if (px !== 9'd6) begin failures++; $display("FAIL en_resume got=%0d exp=6", px); end
    goto(HT - 1, 4, ok);
    step(1);
    checks++;
    if (line_start !== 1'b1 || px !== 9'd0 || py !== 9'd5) begin
      failures++; $display("FAIL line_start_pulse got ls=%b pos=(%0d,%0d) exp=1,(0,5)", line_start, px, py);
    end
    en = 1'b0; step(1);
    checks++;
    if (line_start !== 1'b0) begin failures++; $display("FAIL line_start_width got=%b exp=0", line_start); end
    en = 1'b1;
    goto(0, VBL, ok);
    en = 1'b0; step(3);
    checks++;
    if (vblank !== 1'b0 || px !== 9'd0) begin
      failures++; $display("FAIL en_hold_set got vb=%b x=%0d exp=0,0", vblank, px);
    end
    en = 1'b1; step(1);
    checks++;
    if (vblank !== 1'b1 || px !== 9'd1) begin
      failures++; $display("FAIL en_set got vb=%b x=%0d exp=1,1", vblank, px);
    end
    en = 1'b0; status_rd = 1'b1; step(1); status_rd = 1'b0;
    checks++;
    if (vblank !== 1'b0 || px !== 9'd1) begin
      failures++; $display("FAIL read_while_disabled got vb=%b x=%0d exp=0,1", vblank, px);
    end
    en = 1'b1;
  endtask

  task automatic test_mid_reset;
    bit ok;
    nmi_en = 1'b1;
    goto(0, 0, ok);
    goto(20, 13, ok);
    checks++;
    if (!ok || vblank !== 1'b1 || nmi !== 1'b1) begin
      failures++; $display("FAIL mid_pre got ok=%b vb=%b nmi=%b exp=1,1,1", ok, vblank, nmi);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (px !== 9'd0 || py !== 9'd0 || visible !== 1'b1) begin
      failures++; $display("FAIL async_reset_pos got=(%0d,%0d) vis=%b exp=(0,0),1", px, py, visible);
    end
    checks++;
    if ({vblank, nmi, frame_start, line_start, odd_frame} !== 5'b0) begin
      failures++;
      $display("FAIL async_reset_flags got=%b exp=00000", {vblank, nmi, frame_start, line_start, odd_frame});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    checks++;
    if (px !== 9'd1 || py !== 9'd0 || frame_start !== 1'b0 || line_start !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_resume got=(%0d,%0d) fs=%b ls=%b exp=(1,0),0,0", px, py, frame_start, line_start);
    end
  endtask

  task automatic test_ntsc_line;
    rst_n2 = 1'b1;
    step(255);
    checks++;
    if (nx !== 9'd255 || ny !== 9'd0 || nvis !== 1'b1) begin
      failures++; $display("FAIL ntsc_last_visible got=(%0d,%0d) vis=%b exp=(255,0),1", nx, ny, nvis);
    end
    step(1);
    checks++;
    if (nx !== 9'd256 || nvis !== 1'b0) begin
      failures++; $display("FAIL ntsc_hblank got x=%0d vis=%b exp=256,0", nx, nvis);
    end
    step(84);
    checks++;
    if (nx !== 9'd340 || ny !== 9'd0) begin
      failures++; $display("FAIL ntsc_last_dot got=(%0d,%0d) exp=(340,0)", nx, ny);
    end
    step(1);
    checks++;
    if (nx !== 9'd0 || ny !== 9'd1 || nls !== 1'b1 || nfs !== 1'b0) begin
      failures++; $display("FAIL ntsc_wrap got=(%0d,%0d) ls=%b fs=%b exp=(0,1),1,0", nx, ny, nls, nfs);
    end
    checks++;
    if ({nvb, nnmi, nodd} !== 3'b000) begin
      failures++; $display("FAIL ntsc_flags got=%b exp=000", {nvb, nnmi, nodd});
    end
  endtask

  initial begin
    test_reset();
    test_even_frame();
    test_odd_frame();
    test_odd_norender();
    test_read_race();
    test_nmi_toggle();
    test_en_gating();
    test_mid_reset();
    test_ntsc_line();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
